// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial ripple adder. One full-adder cell is reused for
//             WIDTH cycles, with the carry kept in a flop between cycles.
//             Operands are loaded in parallel and shifted through LSB-first.
//             The result is collected MSB-inserted in a shift register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset
//    start  in   1      load request, honoured only while busy = 0
//    a      in   WIDTH  operand A, sampled on the accepting edge
//    b      in   WIDTH  operand B, sampled on the accepting edge
//    cin    in   1      carry-in, sampled on the accepting edge
//    busy   out  1      addition in progress
//    done   out  1      one-cycle pulse, a new sum/cout is valid
//    sum    out  WIDTH  result of the last completed addition
//    cout   out  1      carry-out of the last completed addition
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q,  a_sr_d;
    logic [WIDTH-1:0] b_sr_q,  b_sr_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Full-adder cell operating on the current LSBs and the held carry.
    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_shift;
    logic             load;

    assign bit_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_nxt = (a_sr_q[0] & b_sr_q[0]) |
                       (a_sr_q[0] & carry_q)   |
                       (b_sr_q[0] & carry_q);
    // After WIDTH insertions at the MSB the first bit has reached bit 0.
    assign res_shift = {bit_s, res_q[WIDTH-1:1]};
    // DONE accepts a new request just like IDLE, enabling back-to-back use.
    assign load      = start && ((state_q == IDLE) || (state_q == DONE));

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = res_shift;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_shift;
                    cout_d  = carry_nxt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Operand load overrides the per-state defaults above.
        if (load) begin
            a_sr_d  = a;
            b_sr_d  = b;
            res_d   = '0;
            carry_d = cin;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = SHIFT;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder at WIDTH 8, 2 and 16.
//             Expected results come from plain integer addition a+b+cin.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       st8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bu8, dn8, co8;
    logic [7:0] su8;

    // WIDTH = 2 instance
    logic       st2 = 1'b0, ci2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       bu2, dn2, co2;
    logic [1:0] su2;

    // WIDTH = 16 instance
    logic        st16 = 1'b0, ci16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        bu16, dn16, co16;
    logic [15:0] su16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(bu8), .done(dn8), .sum(su8), .cout(co8));

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(ci2),
        .busy(bu2), .done(dn2), .sum(su2), .cout(co2));

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .cin(ci16),
        .busy(bu16), .done(dn16), .sum(su16), .cout(co16));

    int total = 0;
    int bad   = 0;

    // Bench's own record of the last completed WIDTH=8 result.
    logic [7:0] last_sum  = '0;
    logic       last_cout = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum with carry as bit WIDTH.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                        input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[8:0];
    endfunction

    // One full WIDTH=8 operation from IDLE, checking busy/done timing and result.
    task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                           input string tag);
        logic [8:0] e;
        e   = ref8(x, y, c);
        st8 = 1'b1; a8 = x; b8 = y; ci8 = c;
        tick();                                  // accepting edge E0
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        check({tag, "_busy0"}, 64'(bu8), 64'd1);
        check({tag, "_hold"},  64'({co8, su8}), 64'({last_cout, last_sum}));
        for (int k = 1; k < 8; k++) begin
            tick();
            check({tag, "_busy"}, 64'({bu8, dn8}), 64'b10);
        end
        tick();                                  // E8
        check({tag, "_done"}, 64'({bu8, dn8}), 64'b01);
        check({tag, "_res"},  64'({co8, su8}), 64'(e));
        last_sum  = e[7:0];
        last_cout = e[8];
        tick();
        check({tag, "_idle"}, 64'({bu8, dn8, co8, su8}), 64'({2'b00, e}));
    endtask

    initial begin
        logic [7:0] va, vb;
        logic       vc;
        logic [8:0] e;
        int         lat;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst8",  64'({bu8, dn8, co8, su8}), 64'd0);
        check("rst2",  64'({bu2, dn2, co2, su2}), 64'd0);
        check("rst16", 64'({bu16, dn16, co16, su16}), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- directed operations ----------------
        run_op8(8'h5A, 8'h3C, 1'b0, "op5A3C");
        run_op8(8'hFF, 8'h01, 1'b0, "opFF01");
        run_op8(8'hFF, 8'hFF, 1'b1, "opFFFFc");

        // ---------------- start while busy, then start in DONE ----------------
        st8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
        tick();                                  // E0 accepts 10+20
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0;      // start stays high
        for (int k = 1; k < 8; k++) begin
            tick();
            check("ign_busy", 64'({bu8, dn8}), 64'b10);
        end
        tick();                                  // E8
        check("ign_done", 64'({bu8, dn8}), 64'b01);
        check("ign_res",  64'({co8, su8}), 64'(ref8(8'h10, 8'h20, 1'b0)));
        tick();                                  // E9 accepts AA+55 from DONE
        check("b2b_load", 64'({bu8, dn8, co8, su8}), 64'({2'b10, 9'h030}));
        st8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            check("b2b_busy", 64'({bu8, dn8}), 64'b10);
        end
        tick();
        check("b2b_done", 64'({bu8, dn8}), 64'b01);
        check("b2b_res",  64'({co8, su8}), 64'(ref8(8'hAA, 8'h55, 1'b0)));
        last_sum = 8'hFF; last_cout = 1'b0;
        tick();
        check("b2b_idle", 64'({bu8, dn8}), 64'b00);

        // ---------------- asynchronous reset mid-operation ----------------
        st8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
        tick();
        st8 = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", 64'(bu8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst", 64'({bu8, dn8, co8, su8}), 64'd0);
        last_sum = '0; last_cout = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("post_rst_quiet", 64'({bu8, dn8, co8, su8}), 64'd0);
        end

        // ---------------- back-to-back random vectors ----------------
        st8 = 1'b1;
        for (int v = 0; v < 200; v++) begin
            va = 8'($urandom); vb = 8'($urandom); vc = 1'($urandom);
            e  = ref8(va, vb, vc);
            a8 = va; b8 = vb; ci8 = vc;
            tick();                              // accepting edge
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            lat = 0;
            do begin
                tick();
                lat++;
            end while (dn8 !== 1'b1 && lat < 24);
            check("rnd_lat", 64'(lat), 64'd8);
            check("rnd_res", 64'({co8, su8}), 64'(e));
        end
        st8 = 1'b0;
        tick();
        check("rnd_end", 64'({bu8, dn8}), 64'b00);

        // ---------------- WIDTH = 2 ----------------
        st2 = 1'b1; a2 = 2'b11; b2 = 2'b11; ci2 = 1'b1;
        tick();
        st2 = 1'b0; a2 = 2'b00; b2 = 2'b00; ci2 = 1'b0;
        check("w2_busy", 64'({bu2, dn2, co2, su2}), 64'b10000);
        tick();
        check("w2_busy1", 64'({bu2, dn2}), 64'b10);
        tick();
        check("w2_done", 64'({bu2, dn2, co2, su2}), 64'b01111);
        tick();
        check("w2_idle", 64'({bu2, dn2}), 64'b00);

        // ---------------- WIDTH = 16 ----------------
        st16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0;
        tick();
        st16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
        for (int k = 1; k < 16; k++) begin
            tick();
            check("w16_busy", 64'({bu16, dn16}), 64'b10);
        end
        tick();
        check("w16_done", 64'({bu16, dn16}), 64'b01);
        check("w16_res",  64'({co16, su16}), 64'h1_0000);
        tick();
        check("w16_idle", 64'({bu16, dn16, co16, su16}), 64'({2'b00, 17'h1_0000}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
